traffic_sensor: RTL and testbench

TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/sensor_debounce.sv | 54 +++++
 rtl/traffic_sensor.sv | 150 +++++++++++++++
 tb/tb_traffic_sensor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic sensor: FSM states, default
// timing parameters, count widths and the saturating wait-count update.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        REQ  = 2'd2
    } state_t;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int MIN_GREEN_DEF  = 20;
    localparam int WAIT_W         = 4;
    localparam int CARS_W         = 8;

    // Rise and fall pulses of one sensor never coincide, so inc wins trivially.
    function automatic logic [WAIT_W-1:0] wait_step(input logic [WAIT_W-1:0] cur,
                                                    input logic              inc,
                                                    input logic              dec);
        if (inc) begin
            return (cur == '1) ? cur : cur + 1'b1;
        end
        if (dec && (cur != '0)) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus run-length debounce for one vehicle loop;
// emits single-cycle registered pulses on debounced rising/falling edges.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       level_reg;
    logic       rise_reg;
    logic       fall_reg;
    logic [3:0] cnt_reg;

    // The level commits on the sample after the disagreement count hits DEB_MAX.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DEB_MAX) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                rise_reg  <= sync2_reg;
                fall_reg  <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/traffic_sensor.sv
// Vehicle-presence front end for a two-way intersection: debounced loop counts
// and a change request to the controller. TRAFFIC_SENSOR_STATS_EN enables CARSx.
module traffic_sensor
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int MIN_GREEN  = MIN_GREEN_DEF
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              SN,
    input  logic              SE,
    input  logic              GN,
    input  logic              GE,
    output logic              T,
    output logic [WAIT_W-1:0] WAITN,
    output logic [WAIT_W-1:0] WAITE,
    output logic [CARS_W-1:0] CARSN,
    output logic [CARS_W-1:0] CARSE
);

    localparam logic [7:0] TIMER_MAX = 8'(MIN_GREEN - 1);

    logic [1:0] raw_vec;
    logic [1:0] green_vec;

    assign raw_vec   = {SE, SN};
    assign green_vec = {GE, GN};

    // Index 0 is north, index 1 is east.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dir
            logic              rise;
            logic              fall;
            logic [WAIT_W-1:0] wait_reg;

            sensor_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk (CLK),
                .srst(CLR),
                .raw (raw_vec[gi]),
                .rise(rise),
                .fall(fall)
            );

            always_ff @(posedge CLK) begin
                if (CLR) begin
                    wait_reg <= '0;
                end else begin
                    wait_reg <= wait_step(wait_reg, rise, fall & green_vec[gi]);
                end
            end

`ifdef TRAFFIC_SENSOR_STATS_EN
            logic [CARS_W-1:0] cars_reg;

            always_ff @(posedge CLK) begin
                if (CLR) begin
                    cars_reg <= '0;
                end else if (rise && (cars_reg != '1)) begin
                    cars_reg <= cars_reg + 1'b1;
                end
            end
`endif
        end
    endgenerate

    assign WAITN = g_dir[0].wait_reg;
    assign WAITE = g_dir[1].wait_reg;

`ifdef TRAFFIC_SENSOR_STATS_EN
    assign CARSN = g_dir[0].cars_reg;
    assign CARSE = g_dir[1].cars_reg;
`else
    assign CARSN = '0;
    assign CARSE = '0;
`endif

    logic [1:0] green_prev_reg;
    logic [7:0] timer_reg;
    logic       green_changed;

    assign green_changed = (green_vec != green_prev_reg);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            green_prev_reg <= 2'b00;
            timer_reg      <= '0;
        end else begin
            green_prev_reg <= green_vec;
            if (green_changed) begin
                timer_reg <= '0;
            end else if (timer_reg != TIMER_MAX) begin
                timer_reg <= timer_reg + 8'd1;
            end
        end
    end

    logic              red_valid;
    logic [WAIT_W-1:0] red_wait;

    always_comb begin
        red_valid = GN ^ GE;
        red_wait  = GN ? WAITE : WAITN;
    end

    state_t state_reg;
    logic   t_reg;

    // Yellow/all-red freezes the FSM; both greens at once is treated as a fault.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg <= IDLE;
            t_reg     <= 1'b0;
        end else if (GN && GE) begin
            state_reg <= IDLE;
            t_reg     <= 1'b0;
        end else if (red_valid) begin
            case (state_reg)
                IDLE: begin
                    if (red_wait != '0) begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (red_wait == '0) begin
                        state_reg <= IDLE;
                    end else if (timer_reg == TIMER_MAX) begin
                        state_reg <= REQ;
                        t_reg     <= 1'b1;
                    end
                end
                REQ: begin
                    if (green_changed) begin
                        state_reg <= IDLE;
                        t_reg     <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    t_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign T = t_reg;

endmodule

// File: tb/tb_traffic_sensor.sv
// Directed bench for traffic_sensor: stimulus schedules expected outputs for
// specific cycles into a scoreboard; a negedge monitor pops and compares them.
module tb_traffic_sensor;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       SN;
    logic       SE;
    logic       GN;
    logic       GE;
    logic       T;
    logic [3:0] WAITN;
    logic [3:0] WAITE;
    logic [7:0] CARSN;
    logic [7:0] CARSE;

    traffic_sensor dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .SN   (SN),
        .SE   (SE),
        .GN   (GN),
        .GE   (GE),
        .T    (T),
        .WAITN(WAITN),
        .WAITE(WAITE),
        .CARSN(CARSN),
        .CARSE(CARSE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

`ifdef TRAFFIC_SENSOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    function automatic logic [7:0] cars(input int n);
        if (!STATS) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    function automatic int sat15(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    typedef struct {
        bit [127:0] name;
        int         idx;
        int         at;
        logic       t;
        logic [3:0] wn;
        logic [3:0] we;
        logic [7:0] cn;
        logic [7:0] ce;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic expect_at(input bit [127:0] name, input int idx, input int at,
                             input logic t, input int wn, input int we,
                             input int cn, input int ce);
        exp_t e;
        int   pos;
        e.name = name;
        e.idx  = idx;
        e.at   = at;
        e.t    = t;
        e.wn   = 4'(wn);
        e.we   = 4'(we);
        e.cn   = cars(cn);
        e.ce   = cars(ce);
        pos = sb_q.size();
        while (pos > 0 && sb_q[pos-1].at > at) pos--;
        sb_q.insert(pos, e);
    endtask

    exp_t m;
    always @(negedge CLK) begin
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            m = sb_q.pop_front();
            n_checks++;
            if (m.at < cyc) begin
                n_errors++;
                $display("FAIL %0s#%0d: slot cycle %0d not checked, now cycle %0d",
                         m.name, m.idx, m.at, cyc);
            end else if (T !== m.t || WAITN !== m.wn || WAITE !== m.we ||
                         CARSN !== m.cn || CARSE !== m.ce) begin
                n_errors++;
                $display("FAIL %0s#%0d @%0d: got T=%b WAITN=%0d WAITE=%0d CARSN=%0d CARSE=%0d, want T=%b WAITN=%0d WAITE=%0d CARSN=%0d CARSE=%0d",
                         m.name, m.idx, cyc, T, WAITN, WAITE, CARSN, CARSE,
                         m.t, m.wn, m.we, m.cn, m.ce);
            end else begin
                $display("ok   %0s#%0d @%0d: T=%b WAITN=%0d WAITE=%0d CARSN=%0d CARSE=%0d",
                         m.name, m.idx, cyc, T, WAITN, WAITE, CARSN, CARSE);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int c0, c1, c2, g0, s, d0, p, q0, e0;

    initial begin
        CLR = 1'b1;
        SN  = 1'b0;
        SE  = 1'b0;
        GN  = 1'b0;
        GE  = 1'b0;
        tick(3);
        CLR = 1'b0;
        expect_at("reset", 0, cyc + 1, 1'b0, 0, 0, 0, 0);
        tick(2);

        // North green, east car arrives: exact WAITE latency, then request.
        GN = 1'b1;
        c0 = cyc;
        tick(1);
        SE = 1'b1;
        c1 = cyc;
        expect_at("waite_pre", 0, c1 + 7, 1'b0, 0, 0, 0, 0);
        expect_at("waite_rise", 0, c1 + 8, 1'b0, 0, 1, 0, 1);
        expect_at("t_pre_min_green", 0, c0 + 20, 1'b0, 0, 1, 0, 1);
        expect_at("t_min_green", 0, c0 + 21, 1'b1, 0, 1, 0, 1);
        tick(20);
        SE = 1'b0;
        tick(11);

        // Yellow while requesting holds T; east green then drops it.
        c2 = cyc;
        GN = 1'b0;
        expect_at("yellow_req", 0, c2 + 1, 1'b1, 0, 1, 0, 1);
        expect_at("yellow_req", 1, c2 + 5, 1'b1, 0, 1, 0, 1);
        expect_at("yellow_req", 2, c2 + 10, 1'b1, 0, 1, 0, 1);
        expect_at("ge_served", 0, c2 + 11, 1'b0, 0, 1, 0, 1);
        tick(10);
        GE = 1'b1;
        tick(2);

        // Bounce shorter than the debounce window must be ignored.
        g0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            expect_at("glitch", i, g0 + 10 * i, 1'b0, 0, 1, 0, 1);
        end
        for (int i = 0; i < 30; i++) begin
            SE = ((i / 2) % 2) == 0;
            tick(1);
        end
        SE = 1'b0;
        tick(12);

        // 17 clean north pulses while east is green: WAITN saturates at 15.
        for (int i = 0; i < 17; i++) begin
            s = cyc;
            expect_at("sat_n", i, s + 9, (i == 0) ? 1'b0 : 1'b1, sat15(i + 1), 1, i + 1, 1);
            SN = 1'b1;
            tick(8);
            SN = 1'b0;
            tick(8);
        end

        // North green: each fall now decrements; rises at 15 are absorbed.
        GN = 1'b1;
        GE = 1'b0;
        d0 = cyc;
        tick(4);
        for (int j = 0; j < 16; j++) begin
            p = cyc;
            expect_at("dec_rise", j, p + 12, (p + 12 >= d0 + 21), 15, 1, 18 + j, 1);
            expect_at("dec_fall", j, p + 20, (p + 20 >= d0 + 21), 14, 1, 18 + j, 1);
            SN = 1'b1;
            tick(8);
            SN = 1'b0;
            tick(8);
        end
        tick(8);

        // Two more east cars (east red), then a one-cycle reset mid-request.
        q0 = cyc;
        expect_at("we3_req", 0, q0 + 30, 1'b1, 14, 3, 33, 3);
        for (int k = 0; k < 2; k++) begin
            SE = 1'b1;
            tick(8);
            SE = 1'b0;
            tick(8);
        end
        CLR = 1'b1;
        expect_at("clr_in_req", 0, q0 + 33, 1'b0, 0, 0, 0, 0);
        tick(1);
        CLR = 1'b0;
        expect_at("after_clr", 0, q0 + 40, 1'b0, 0, 0, 0, 0);
        tick(7);

        // Yellow during HOLD freezes the FSM; request follows the new green.
        e0 = cyc;
        SE = 1'b1;
        expect_at("yellow_hold", 0, e0 + 10, 1'b0, 0, 1, 0, 1);
        expect_at("yellow_hold", 1, e0 + 15, 1'b0, 0, 1, 0, 1);
        expect_at("yellow_hold", 2, e0 + 19, 1'b0, 0, 1, 0, 1);
        expect_at("hold_pre_req", 0, e0 + 39, 1'b0, 0, 1, 0, 1);
        expect_at("hold_req", 0, e0 + 40, 1'b1, 0, 1, 0, 1);
        tick(9);
        GN = 1'b0;
        tick(10);
        GN = 1'b1;
        tick(24);
        tick(3);

        while (sb_q.size() > 0) begin
            m = sb_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %0s#%0d: slot cycle %0d never reached", m.name, m.idx, m.at);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
